// File: rtl/v_alu_pkg.sv
// Shared types and constants for the vector subtract datapath.
package v_alu_pkg;
  localparam int WORD_W   = 16;
  localparam int VLEN_DEF = 8;

  localparam logic [WORD_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WORD_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/ks_subtract_16.sv
// Combinational 16-bit subtract computed as a + ~b + !bin through a Kogge-Stone carry tree.
module ks_subtract_16
  import v_alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic [WORD_W-1:0] diff,
  output logic              bout,
  output logic              ovf
);
  localparam int LVLS = $clog2(WORD_W);

  logic [WORD_W-1:0] gl [LVLS+1];
  logic [WORD_W-1:0] pl [LVLS+1];
  logic [WORD_W:0]   c;

  always_comb begin
    gl[0] = a & ~b;
    pl[0] = a ^ ~b;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i - (1 << l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i - (1 << l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    // The carry-in of an inverted-operand subtract is the complement of the borrow-in.
    c[0] = !bin;
    for (int i = 0; i < WORD_W; i++) begin
      c[i+1] = gl[LVLS][i] | (pl[LVLS][i] & c[0]);
    end
    diff = pl[0] ^ c[WORD_W-1:0];
    bout = !c[WORD_W];
    ovf  = c[WORD_W] ^ c[WORD_W-1];
  end
endmodule

// File: rtl/v_subtractor_pipe.sv
// Two-stage valid/ready vector element subtractor with element counter and IDLE/RUN tracking.
// Define V_SUB_SAT_EN to saturate the difference on signed overflow.
module v_subtractor_pipe
  import v_alu_pkg::*;
#(
  parameter int VLEN = VLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_diff,
  output logic              out_bout,
  output logic              out_ovf,
  output logic              out_last,
  output logic              busy
);
  logic [WORD_W-1:0] a_p0, b_p0;
  logic              bin_p0, vld_p0;
  logic [WORD_W-1:0] diff_p1;
  logic              bout_p1, ovf_p1, vld_p1;
  logic [7:0]        count;
  state_t            state, state_nxt;
  logic              s2_load, s1_adv, in_fire, out_fire;
  logic [WORD_W-1:0] ks_diff, res_diff;
  logic              ks_bout, ks_ovf;

  assign s2_load  = !vld_p1 || out_ready;
  assign s1_adv   = vld_p0 && s2_load;
  assign in_ready = !rst && (!vld_p0 || s2_load);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_p1 && out_ready;

`ifdef V_SUB_SAT_EN
  function automatic logic [WORD_W-1:0] sat_word(input logic [WORD_W-1:0] d,
                                                 input logic              ov);
    // A wrapped result with the sign bit set means the true value overflowed upward.
    if (!ov) return d;
    return d[WORD_W-1] ? SAT_POS : SAT_NEG;
  endfunction

  assign res_diff = sat_word(ks_diff, ks_ovf);
`else
  assign res_diff = ks_diff;
`endif

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    if (rst)          vld_p0 <= 1'b0;
    else if (in_fire) vld_p0 <= 1'b1;
    else if (s1_adv)  vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_p0   <= in_a;
      b_p0   <= in_b;
      bin_p0 <= in_bin;
    end
  end

  ks_subtract_16 u_sub (
    .a    (a_p0),
    .b    (b_p0),
    .bin  (bin_p0),
    .diff (ks_diff),
    .bout (ks_bout),
    .ovf  (ks_ovf)
  );

  // Stage p1: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      diff_p1 <= '0;
      bout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (s2_load) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        diff_p1 <= res_diff;
        bout_p1 <= ks_bout;
        ovf_p1  <= ks_ovf;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_diff  = diff_p1;
  assign out_bout  = bout_p1;
  assign out_ovf   = ovf_p1;
  assign out_last  = vld_p1 && (count == 8'(VLEN - 1));

  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (out_fire) count <= out_last ? 8'd0 : count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire) state_nxt = RUN;
      RUN:  if (out_fire && out_last && !vld_p0 && !in_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
endmodule

// File: tb/tb_v_subtractor_pipe.sv
// Self-checking bench: directed table, streaming/stall/reset sequences and random traffic vs. a reference model.
module tb_v_subtractor_pipe;
  localparam int VLEN = 8;
`ifdef V_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_diff;
  logic        out_bout, out_ovf, out_last, busy;

  v_subtractor_pipe #(.VLEN(VLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_bout(out_bout),
    .out_ovf(out_ovf), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   outcnt = 0;
  exp_t expq[$];
  bit   rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int   r, u;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    u = int'(a) - int'(b) - int'(bin);
    e.diff = 16'(u);
    e.bout = (u < 0);
    e.ovf  = (r > 32767) || (r < -32768);
    if (SAT && e.ovf) e.diff = (r > 32767) ? 16'h7FFF : 16'h8000;
    return e;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
    in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: model queue filled on input transfers, drained and compared on output transfers.
  task automatic monitor();
    exp_t        e;
    bit          stall = 1'b0;
    logic [15:0] h_diff;
    logic        h_bout, h_ovf, h_last;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        outcnt = 0;
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_diff", 32'(out_diff), 32'(h_diff));
        chk("hold_flags", 32'({out_bout, out_ovf, out_last}), 32'({h_bout, h_ovf, h_last}));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("diff", 32'(out_diff), 32'(e.diff));
          chk("bout", 32'(out_bout), 32'(e.bout));
          chk("ovf", 32'(out_ovf), 32'(e.ovf));
          chk("last", 32'(out_last), 32'((outcnt % VLEN) == VLEN - 1));
        end
        outcnt++;
      end
      stall  = out_valid && !out_ready;
      h_diff = out_diff; h_bout = out_bout; h_ovf = out_ovf; h_last = out_last;
      if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_bin));
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1};
    tbl[3] = '{16'h7FFF, 16'hFFFF, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h0000, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1};

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_diff", 32'(out_diff), 32'd0);
    chk("rst_flags", 32'({out_bout, out_ovf, out_last}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, one element at a time with latency check
    for (int k = 0; k < 7; k++) begin
      int n;
      send(tbl[k].a, tbl[k].b, tbl[k].bin);
      for (n = 0; n < 10; n++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      chk("latency", 32'(n), 32'd1);
      chk("tbl_diff", 32'(out_diff), 32'(tbl[k].diff));
      chk("tbl_bout", 32'(out_bout), 32'(tbl[k].bout));
      chk("tbl_ovf", 32'(out_ovf), 32'(tbl[k].ovf));
      @(posedge clk); #1;
    end

    // Full vector with out_ready toggling every cycle
    pulse_rst();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          out_ready = !out_ready;
        end
      end
      begin
        for (int i = 0; i < VLEN; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom));
          if (i == 0) chk("busy_run", 32'(busy), 32'd1);
        end
      end
    join
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("vec_outcnt", 32'(outcnt), 32'(VLEN));
    chk("vec_busy_idle", 32'(busy), 32'd0);

    // Reset in the middle of a vector
    pulse_rst();
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < VLEN; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    for (int n = 0; n < 20 && outcnt < VLEN; n++) @(posedge clk);
    #1;
    chk("midrst_outcnt", 32'(outcnt), 32'(VLEN));
    chk("midrst_busy_idle", 32'(busy), 32'd0);

    // Random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 37 * VLEN; i++) begin
          logic [15:0] a, b;
          a = 16'($urandom);
          b = 16'($urandom);
          case ($urandom_range(0, 5))
            0: a = 16'h8000;
            1: b = 16'h7FFF;
            2: a = 16'hFFFF;
            default: ;
          endcase
          send(a, b, 1'($urandom));
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 50 && expq.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", 32'(expq.size()), 32'd0);
    chk("rnd_busy_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/v_subtractor_pipe.md
V_SUBTRACTOR_PIPE -- requirements
Module: v_subtractor_pipe

Interface
REQ-001 SHALL have parameter VLEN, default 8, meaning number of 16-bit elements per vector (2..256).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  element A/B/in_bin present.
REQ-005 SHALL have port in_ready  output  1  block accepts element this cycle.
REQ-006 SHALL have port in_a  input  16  minuend.
REQ-007 SHALL have port in_b  input  16  subtrahend.
REQ-008 SHALL have port in_bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_diff  output  16  difference.
REQ-012 SHALL have port out_bout  output  1  unsigned borrow-out.
REQ-013 SHALL have port out_ovf  output  1  signed overflow flag.
REQ-014 SHALL have port out_last  output  1  result is element VLEN-1 of current vector.
REQ-015 SHALL have port busy  output  1  FSM in RUN.

Function
REQ-016 Transfer SHALL occur only when valid and ready both high on a clk edge; no element dropped or duplicated.
REQ-017 SHALL be a 2-stage pipeline: S1 registers operands, S2 registers result; latency 2 cycles from input transfer to out_valid with no backpressure; throughput 1 element/cycle.
REQ-018 S2 SHALL load when empty or out_ready high; S1 SHALL load when empty or S1 advancing; in_ready = !S1_valid || (!S2_valid || out_ready).
REQ-019 While out_valid high and out_ready low, out_diff/out_bout/out_ovf/out_last SHALL hold stable.
REQ-020 out_diff SHALL equal (in_a - in_b - in_bin) mod 2^16; out_bout SHALL be 1 iff in_a < in_b + in_bin (unsigned, 17-bit compare).
REQ-021 out_ovf SHALL be 1 iff signed result of in_a - in_b - in_bin lies outside [-32768, 32767].
REQ-022 Element counter (8-bit) SHALL increment on each output transfer and wrap to 0 after VLEN-1; out_last = out_valid && count == VLEN-1.
REQ-023 FSM states: IDLE, RUN. IDLE->RUN on first input transfer; RUN->IDLE on output transfer with out_last high and no element in S1 or entering; otherwise stay RUN (back-to-back vectors remain in RUN).
REQ-024 Simultaneous input and output transfer in same cycle SHALL both complete with no bubble.

Reset
REQ-025 On rst high at clk edge: S1/S2 valid cleared, counter 0, FSM IDLE, out_valid 0, out_diff 0, out_bout 0, out_ovf 0, out_last 0, busy 0.
REQ-026 in_ready SHALL be 0 while rst is high; reset mid-vector SHALL discard all in-flight elements and restart count at 0.

Configuration
REQ-027 Macro V_SUB_SAT_EN defined: on out_ovf, out_diff SHALL saturate to 0x7FFF (positive overflow) or 0x8000 (negative overflow); out_ovf still asserted.
REQ-028 Macro V_SUB_SAT_EN undefined: out_diff SHALL wrap per REQ-020; saturation logic absent.

Structure
REQ-029 Shared package v_alu_pkg SHALL hold WORD_W=16, default VLEN, FSM state enum, SAT_POS=0x7FFF, SAT_NEG=0x8000.
REQ-030 Sub-module ks_subtract_16 SHALL implement the combinational 16-bit subtract (A + ~B + !bin via prefix carry network) returning diff, bout, ovf; instantiated once between S1 and S2.

Verification
REQ-031 A=0x0005, B=0x0003, bin=0, out_ready=1 -> 2 cycles later diff=0x0002, bout=0, ovf=0.
REQ-032 A=0x0000, B=0x0000, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
REQ-033 A=0x8000, B=0x0001, bin=0 -> ovf=1; diff=0x7FFF without V_SUB_SAT_EN, 0x8000 with it.
REQ-034 Stream 8 elements, VLEN=8, out_ready toggling 1/0 each cycle -> 8 results in order, held during stalls, out_last only on 8th, busy drops after it.
REQ-035 Assert rst after 3 of 8 elements accepted -> next cycle out_valid=0, busy=0; new vector's 8th element carries out_last.
